vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised VGA timing generator with a built-in, runtime-selectable test-pattern source. It produces hsync/vsync/data-enable, pixel coordinates and RGB for any resolution and colour depth. It also adds frame-synchronous mode switching and an animated bouncing-box pattern. It sits directly in front of the board's VGA pins for bring-up and monitor checks, and its coordinate outputs can drive other pixel sources.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync in lines
- HS_POL / VS_POL, 0 / 0, active level of hsync / vsync
- COLOR_W, 4, bits per colour channel
- BOX_SIZE, 32, side of the moving box in pixels; must be less than both V_ACTIVE and H_ACTIVE
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; the block advances one pixel per clk with pix_en high
- mode  in  3  pattern select, sampled at frame start
- solid_rgb  in  3*COLOR_W  colour for solid mode, as {R,G,B}, sampled at frame start
- hsync, vsync  out  1  sync outputs at the HS_POL / VS_POL level
- de  out  1  high for active pixels
- xpos, ypos  out  11  coordinates of the current output pixel; 0 outside the active area
- frame_start  out  1  one-pixel pulse aligned with pixel (0,0)
- vga_red, vga_green, vga_blue  out  COLOR_W  pixel colour; 0 when de is low

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. On that wrap, v_cnt increments, wrapping 0..V_TOTAL-1.
- Line order: active [0, H_ACTIVE-1], then front porch, then sync, then back porch. The same order applies vertically.
- Sync is active while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync follows the same rule on v_cnt. The vsync period is counted in whole lines.
- de = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- At h_cnt==0 and v_cnt==0 (frame start), the block latches mode and solid_rgb into cur_mode and cur_rgb, and updates the box position. Changes between frame starts have no effect.
- Modes:
  - 0 colour bars: 8 vertical bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black. Any remainder columns are black.
  - 1 checkerboard: white when x[5] xor y[5] is 1, otherwise black.
  - 2 grid: white when x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; otherwise black.
  - 3 grey ramp: all channels = min(x >> GS, 2^COLOR_W-1), where GS = clog2(H_ACTIVE)-COLOR_W, floored at 0.
  - 4 solid: cur_rgb.
  - 5 bouncing box: white inside [bx, bx+BOX_SIZE-1] x [by, by+BOX_SIZE-1]; black elsewhere.
  - 6, 7: black.
- Full intensity (white) is all ones in every channel.
- Box update, applied each frame start independent of mode:
  - If dx=+ and bx==H_ACTIVE-BOX_SIZE, set dx=- and bx=bx-1.
  - If dx=- and bx==0, set dx=+ and bx=1.
  - Otherwise bx moves one step in direction dx.
  - by and dy follow the same rule, with limit V_ACTIVE-BOX_SIZE.

## Timing
- Output latency is one pix_en cycle after the counters. All outputs are registered and aligned to each other: sync, de, xpos, ypos, frame_start and RGB describe the same pixel.
- When pix_en is low, counters, box state and all outputs hold.
- Reset values: h_cnt=v_cnt=0, hsync=~HS_POL, vsync=~VS_POL, de=0, xpos=ypos=0, frame_start=0, RGB=0, bx=by=0, dx=dy=+, cur_mode=0, cur_rgb=0.
- Reset asserted mid-frame takes effect on the next clk edge regardless of pix_en.
- After reset releases, the first pix_en cycle processes pixel (0,0). That cycle latches mode and does the box update, so the box is at (1,1) for the first frame. frame_start is high on the second pix_en cycle.
- Frame period is H_TOTAL*V_TOTAL pix_en cycles: 800*525 = 420000 with the defaults.

## Structure
- Shared package vga_pkg holds the mode encodings (MODE_BARS through MODE_BOX), the 8 bar colours as 3-bit on/off masks expanded to COLOR_W, and a clog2 function.
- Sub-module vga_timing_core contains the counters, sync and de decode, and the position outputs, plus its own parameters.
- vga_pattern_gen instantiates vga_timing_core and adds the mode latch, box state machine, pattern decode and output register stage.

## Test plan
- Defaults, pix_en=1: hsync low for exactly 96 clocks per 800-clock line. vsync low for exactly 2*800 clocks per 420000-clock frame. de high 640 clocks per line on 480 lines.
- Mode 0: pixel x=0 is F/F/F, x=80 is F/F/0 (yellow), x=560 is 0/0/0. RGB is 0 whenever de=0.
- Mode changes from 1 to 4 mid-frame with solid_rgb=12'hA5C: the rest of that frame stays checkerboard. The next frame is A/5/C on every active pixel.
- Mode 5 over 610 frames: bx reaches 608 at frame 608, then is 607 at frame 609. by reverses after 448, then 447.
- Reset asserted at line 200, pixel 300: next clock all outputs hold their reset values. frame_start fires one pix_en cycle after the first pixel following reset.
- pix_en=1 every third clk: the output sequence is identical to the pix_en=1 run, with each value held for 3 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pkg: pattern mode encodings, colour-bar masks, clog2 helper
// Revision: 1.0
// ------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [2:0] {
    MODE_BARS    = 3'd0,
    MODE_CHECKER = 3'd1,
    MODE_GRID    = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_SOLID   = 3'd4,
    MODE_BOX     = 3'd5
  } mode_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  // {R,G,B} on/off masks, left to right: white yellow cyan green magenta red blue black
  localparam logic [2:0] BAR_MASK [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_timing_core: h/v counters with registered sync, de and position
// Revision: 1.0
// ------------------------------------------------------------------
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        active,
  output logic        at_origin,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [10:0] xpos,
  output logic [10:0] ypos
);

  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic hs_on;
  logic vs_on;

  always_comb begin
    active    = (h_cnt < 12'(H_ACTIVE)) && (v_cnt < 12'(V_ACTIVE));
    at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    hs_on     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_on     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      de          <= active;
      frame_start <= at_origin;
      xpos        <= active ? h_cnt[10:0] : 11'd0;
      ypos        <= active ? v_cnt[10:0] : 11'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pattern_gen: VGA timing plus frame-synchronous test-pattern source
// Revision: 1.0
// ------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int BOX_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [10:0]            xpos,
  output logic [10:0]            ypos,
  output logic                   frame_start,
  output logic [COLOR_W-1:0]     vga_red,
  output logic [COLOR_W-1:0]     vga_green,
  output logic [COLOR_W-1:0]     vga_blue
);

  localparam int                 GS_RAW = clog2(H_ACTIVE) - COLOR_W;
  localparam int                 GS     = (GS_RAW < 0) ? 0 : GS_RAW;
  localparam int                 BAR_W  = H_ACTIVE / 8;
  localparam int                 FULL_I = (1 << COLOR_W) - 1;
  localparam logic [COLOR_W-1:0] FULL   = '1;
  localparam logic [11:0]        BX_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0]        BY_MAX = 12'(V_ACTIVE - BOX_SIZE);

  logic [11:0] h_cnt, v_cnt;
  logic        active, at_origin;

  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active), .at_origin(at_origin),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .xpos(xpos), .ypos(ypos)
  );

  mode_e                cur_mode, eff_mode;
  logic [3*COLOR_W-1:0] cur_rgb, eff_rgb;
  logic [11:0]          bx, by, bx_nxt, by_nxt, eff_bx, eff_by;
  dir_e                 dx, dy, dx_nxt, dy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= MODE_BARS;
      cur_rgb  <= '0;
      bx       <= '0;
      by       <= '0;
      dx       <= DIR_POS;
      dy       <= DIR_POS;
    end else if (pix_en && at_origin) begin
      cur_mode <= mode_e'(mode);
      cur_rgb  <= solid_rgb;
      bx       <= bx_nxt;
      by       <= by_nxt;
      dx       <= dx_nxt;
      dy       <= dy_nxt;
    end
  end

  always_comb begin
    bx_nxt = bx;
    dx_nxt = dx;
    by_nxt = by;
    dy_nxt = dy;
    if (dx == DIR_POS) begin
      if (bx == BX_MAX) begin dx_nxt = DIR_NEG; bx_nxt = bx - 12'd1; end
      else                    bx_nxt = bx + 12'd1;
    end else begin
      if (bx == 12'd0) begin dx_nxt = DIR_POS; bx_nxt = 12'd1; end
      else                   bx_nxt = bx - 12'd1;
    end
    if (dy == DIR_POS) begin
      if (by == BY_MAX) begin dy_nxt = DIR_NEG; by_nxt = by - 12'd1; end
      else                    by_nxt = by + 12'd1;
    end else begin
      if (by == 12'd0) begin dy_nxt = DIR_POS; by_nxt = 12'd1; end
      else                   by_nxt = by - 12'd1;
    end
  end

  // Pixel (0,0) is decoded with the values being latched on that same edge
  always_comb begin
    eff_mode = at_origin ? mode_e'(mode) : cur_mode;
    eff_rgb  = at_origin ? solid_rgb : cur_rgb;
    eff_bx   = at_origin ? bx_nxt : bx;
    eff_by   = at_origin ? by_nxt : by;
  end

  logic [11:0]        bar_idx, ramp;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] ramp_lvl, pr, pg, pb;
  logic               in_box;

  always_comb begin
    pr       = '0;
    pg       = '0;
    pb       = '0;
    bar_idx  = h_cnt / 12'(BAR_W);
    bar      = (bar_idx < 12'd8) ? BAR_MASK[bar_idx[2:0]] : 3'b000;
    ramp     = h_cnt >> GS;
    ramp_lvl = (ramp > 12'(FULL_I)) ? FULL : ramp[COLOR_W-1:0];
    in_box   = (h_cnt >= eff_bx) && (h_cnt < eff_bx + 12'(BOX_SIZE)) &&
               (v_cnt >= eff_by) && (v_cnt < eff_by + 12'(BOX_SIZE));
    case (eff_mode)
      MODE_BARS: begin
        pr = {COLOR_W{bar[2]}};
        pg = {COLOR_W{bar[1]}};
        pb = {COLOR_W{bar[0]}};
      end
      MODE_CHECKER: if (h_cnt[5] ^ v_cnt[5]) {pr, pg, pb} = {3{FULL}};
      MODE_GRID: begin
        if ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0) ||
            (h_cnt == 12'(H_ACTIVE - 1)) || (v_cnt == 12'(V_ACTIVE - 1)))
          {pr, pg, pb} = {3{FULL}};
      end
      MODE_RAMP:  {pr, pg, pb} = {3{ramp_lvl}};
      MODE_SOLID: {pr, pg, pb} = eff_rgb;
      MODE_BOX:   if (in_box) {pr, pg, pb} = {3{FULL}};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else if (pix_en) begin
      vga_red   <= active ? pr : '0;
      vga_green <= active ? pg : '0;
      vga_blue  <= active ? pb : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vga_pattern_gen: randomized bench against a frame-level pixel model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int HA = 42, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 36, VFP = 1, VSY = 2, VBP = 1;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int CW  = 4;
  localparam int BOX = 24;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT;
  localparam int GS  = ($clog2(HA) > CW) ? ($clog2(HA) - CW) : 0;
  localparam int WH  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic [2:0]    mode;
  logic [11:0]   solid_rgb;
  logic          hsync, vsync, de, frame_start;
  logic [10:0]   xpos, ypos;
  logic [CW-1:0] vga_red, vga_green, vga_blue;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(CW), .BOX_SIZE(BOX)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .xpos(xpos), .ypos(ypos),
    .frame_start(frame_start), .vga_red(vga_red), .vga_green(vga_green),
    .vga_blue(vga_blue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: position in frame, frame starts since reset, latched settings
  int          p, nfs;
  int          m_mode;
  logic [11:0] m_rgb;
  bit          e_hs, e_vs, e_de, e_fs;
  int          e_x, e_y, e_rgb;
  int          bar_tab [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Triangle wave: frame n of a 0..lim bounce that starts moving up from 0
  function automatic int bounce_pos(input int n, input int lim);
    int r;
    r = n % (2 * lim);
    return (r <= lim) ? r : (2 * lim - r);
  endfunction

  function automatic int expand(input int mask);
    return (((mask >> 2) & 1) * WH << (2 * CW)) | (((mask >> 1) & 1) * WH << CW) | ((mask & 1) * WH);
  endfunction

  function automatic int ref_color(input int x, input int y);
    int bx, by, col, g;
    bx = bounce_pos(nfs, HA - BOX);
    by = bounce_pos(nfs, VA - BOX);
    case (m_mode)
      0: begin
        col = x / (HA / 8);
        return (col < 8) ? expand(bar_tab[col]) : 0;
      end
      1: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? expand(7) : 0;
      2: return (x % 32 == 0 || y % 32 == 0 || x == HA - 1 || y == VA - 1) ? expand(7) : 0;
      3: begin
        g = x >> GS;
        if (g > WH) g = WH;
        return (g << (2 * CW)) | (g << CW) | g;
      end
      4: return int'(m_rgb);
      5: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? expand(7) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int h, v;
    if (rst) begin
      p = 0; nfs = 0; m_mode = 0; m_rgb = '0;
      e_hs = !HS_POL; e_vs = !VS_POL; e_de = 0; e_fs = 0;
      e_x = 0; e_y = 0; e_rgb = 0;
    end else if (pix_en) begin
      h = p % HT;
      v = p / HT;
      if (p == 0) begin
        nfs++;
        m_mode = int'(mode);
        m_rgb  = solid_rgb;
      end
      e_de  = (h < HA) && (v < VA);
      e_hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : !HS_POL;
      e_vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : !VS_POL;
      e_x   = e_de ? h : 0;
      e_y   = e_de ? v : 0;
      e_fs  = (p == 0);
      e_rgb = e_de ? ref_color(h, v) : 0;
      p = (p + 1) % FR;
    end
  endtask

  task automatic check_outputs();
    check_val("hsync", hsync, e_hs);
    check_val("vsync", vsync, e_vs);
    check_val("de", de, e_de);
    check_val("xpos", xpos, e_x);
    check_val("ypos", ypos, e_y);
    check_val("frame_start", frame_start, e_fs);
    check_val("rgb", {vga_red, vga_green, vga_blue}, e_rgb);
  endtask

  // One clock: check the state left by the last edge, then drive the next one
  task automatic cycle(input bit r, input bit en, input logic [2:0] md, input logic [11:0] srgb);
    @(negedge clk);
    check_outputs();
    rst = r; pix_en = en; mode = md; solid_rgb = srgb;
    model_step();
  endtask

  initial begin
    logic [2:0]  rmode;
    logic [11:0] rrgb;
    rst = 1'b1; pix_en = 1'b0; mode = 3'd0; solid_rgb = 12'h000;
    model_step();

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(1, 0)), 3'd0, 12'h000);

    // Colour bars, continuous pixel strobe
    for (int i = 0; i < FR; i++) cycle(1'b0, 1'b1, 3'd0, 12'h000);

    // Checkerboard, switched to solid mid-frame
    for (int i = 0; i < FR / 2; i++)     cycle(1'b0, 1'b1, 3'd1, 12'h123);
    for (int i = 0; i < 3 * FR / 2; i++) cycle(1'b0, 1'b1, 3'd4, 12'hA5C);

    // Pixel strobe every third clock
    for (int i = 0; i < 3 * FR; i++) cycle(1'b0, (i % 3) == 0, 3'd5, 12'h000);

    // Random strobe; random modes first, then the box through both bounces
    rmode = 3'd2; rrgb = 12'h0F0;
    for (int i = 0; i < 60000 && nfs < 21; i++) begin
      if (nfs >= 10) rmode = 3'd5;
      else if ($urandom_range(699, 0) == 0) begin
        rmode = 3'($urandom_range(7, 0));
        rrgb  = 12'($urandom);
      end
      cycle(1'b0, $urandom_range(7, 0) != 0, rmode, rrgb);
    end

    // Reset mid-frame with the strobe low, then a ramp frame
    for (int i = 0; i < 3 * FR && p != 20 * HT + 25; i++)
      cycle(1'b0, $urandom_range(3, 0) != 0, 3'd5, 12'h000);
    cycle(1'b1, 1'b0, 3'd3, 12'h000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'd3, 12'h000);
    for (int i = 0; i < FR + 60; i++) cycle(1'b0, 1'b1, 3'd3, 12'h000);

    @(negedge clk);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
